// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone B4 classic arbiter with round-robin tie-break and cyc-held ownership.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int GRANULARITY = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             m0_adr_i,
  input  logic [DATA_WIDTH-1:0]             m0_dat_i,
  output logic [DATA_WIDTH-1:0]             m0_dat_o,
  input  logic                              m0_we_i,
  input  logic [DATA_WIDTH/GRANULARITY-1:0] m0_sel_i,
  input  logic                              m0_stb_i,
  input  logic                              m0_cyc_i,
  output logic                              m0_ack_o,
  output logic                              m0_err_o,
  input  logic [ADDR_WIDTH-1:0]             m1_adr_i,
  input  logic [DATA_WIDTH-1:0]             m1_dat_i,
  output logic [DATA_WIDTH-1:0]             m1_dat_o,
  input  logic                              m1_we_i,
  input  logic [DATA_WIDTH/GRANULARITY-1:0] m1_sel_i,
  input  logic                              m1_stb_i,
  input  logic                              m1_cyc_i,
  output logic                              m1_ack_o,
  output logic                              m1_err_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  output logic                              s_we_o,
  output logic [DATA_WIDTH/GRANULARITY-1:0] s_sel_o,
  output logic                              s_stb_o,
  output logic                              s_cyc_o,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [1:0]                        grant_o
);

  localparam int SW = DATA_WIDTH / GRANULARITY;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_rr_arbiter: TIMEOUT must be within 1..65535");
  end

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state, state_next;
  logic   last, last_next;   // last winner: 0 = m0, 1 = m1

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_next = state;
    last_next  = last;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_next = last ? OWN0 : OWN1;
          last_next  = ~last;
        end else if (m0_cyc_i) begin
          state_next = OWN0;
          last_next  = 1'b0;
        end else if (m1_cyc_i) begin
          state_next = OWN1;
          last_next  = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc_i) state_next = IDLE;
      OWN1:    if (!m1_cyc_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst blanks the slave side immediately when reset is asserted mid-transfer.
  logic own0, own1, stb_raw, to_hit;
  assign own0    = rst && (state == OWN0);
  assign own1    = rst && (state == OWN1);
  assign stb_raw = (own0 && m0_cyc_i && m0_stb_i) || (own1 && m1_cyc_i && m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = (to_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if ((state_next != state) || to_hit || s_ack_i || s_err_i) begin
      to_cnt <= '0;
    end else if (stb_raw) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
    end
  end

  assign s_cyc_o  = (own0 && m0_cyc_i) || (own1 && m1_cyc_i);
  assign s_stb_o  = stb_raw && !to_hit;
  assign grant_o  = {own1, own0};

  // Responses also require the owner's cyc, so an abandoned cycle never sees a late ack.
  assign m0_ack_o = own0 && m0_cyc_i && s_ack_i;
  assign m1_ack_o = own1 && m1_cyc_i && s_ack_i;
  assign m0_err_o = own0 && ((m0_cyc_i && s_err_i) || to_hit);
  assign m1_err_o = own1 && ((m1_cyc_i && s_err_i) || to_hit);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  logic [SW-1:0] unused_sw;
  assign unused_sw = '0;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized traffic against a cycle model.
// Build with WB_ARB_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT=8 here).
module tb_wb_rr_arbiter;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat, s_dat_i;
  logic          m0_we, m1_we, s_we, m0_stb, m1_stb, s_stb, m0_cyc, m1_cyc, s_cyc;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_ack, m1_ack, m0_err, m1_err, s_ack, s_err;
  logic [1:0]    grant;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRANULARITY(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_dat_i(s_dat_i), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant)
  );

  // Reference model: who owns the bus, who won last, and how long the slave has stalled.
  int mdl_owner = -1;
  int mdl_last  = 1;
  int mdl_cnt   = 0;

  logic          e_own0, e_own1, e_hit, e_raw, e_cyc, e_stb, e_we;
  logic          e_ack0, e_ack1, e_err0, e_err1;
  logic [1:0]    e_grant;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [SW-1:0] e_sel;

  always_comb begin
    e_own0  = rst && (mdl_owner == 0);
    e_own1  = rst && (mdl_owner == 1);
    e_hit   = TO_ON && (mdl_cnt == TO);
    e_cyc   = (e_own0 && m0_cyc) || (e_own1 && m1_cyc);
    e_raw   = (e_own0 && m0_cyc && m0_stb) || (e_own1 && m1_cyc && m1_stb);
    e_stb   = e_raw && !e_hit;
    e_grant = {e_own1, e_own0};
    e_adr   = e_own0 ? m0_adr : (e_own1 ? m1_adr : '0);
    e_dat   = e_own0 ? m0_dat : (e_own1 ? m1_dat : '0);
    e_sel   = e_own0 ? m0_sel : (e_own1 ? m1_sel : '0);
    e_we    = e_own0 ? m0_we  : (e_own1 ? m1_we  : 1'b0);
    e_ack0  = e_own0 && m0_cyc && s_ack;
    e_ack1  = e_own1 && m1_cyc && s_ack;
    e_err0  = e_own0 && ((m0_cyc && s_err) || e_hit);
    e_err1  = e_own1 && ((m1_cyc && s_err) || e_hit);
  end

  always @(posedge clk) begin
    int nxt;
    if (!rst) begin
      mdl_owner = -1;
      mdl_last  = 1;
      mdl_cnt   = 0;
    end else begin
      if (mdl_owner < 0) begin
        if (m0_cyc && m1_cyc) nxt = (mdl_last == 1) ? 0 : 1;
        else if (m0_cyc)      nxt = 0;
        else if (m1_cyc)      nxt = 1;
        else                  nxt = -1;
        if (nxt >= 0) mdl_last = nxt;
      end else begin
        nxt = ((mdl_owner == 0) ? m0_cyc : m1_cyc) ? mdl_owner : -1;
      end
      if (nxt != mdl_owner || e_hit || s_ack || s_err) mdl_cnt = 0;
      else if (e_raw) mdl_cnt = mdl_cnt + 1;
      mdl_owner = nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      n_checks++;
      if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 ||
          s_adr !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: grant=%b s_cyc=%b s_stb=%b ack=%b%b adr=%h, want all zero",
                 i, grant, s_cyc, s_stb, m1_ack, m0_ack, s_adr);
      end
    end
    rst = 1;
    #1;
    n_checks++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release_idle: grant=%b want 00", grant);
    end
    step();
    n_checks++;
    if (grant !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_first_grant: grant=%b want 01", grant);
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] rd;
    rd = {$urandom, $urandom, $urandom, $urandom};
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h40;
    #1;
    n_checks++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL single_pre_grant: grant=%b want 00", grant);
    end
    step();
    n_checks++;
    if (grant !== 2'b10 || s_adr !== 32'h40 || s_stb !== 1'b1 || s_cyc !== 1'b1 || s_we !== 1'b0) begin
      n_bad++;
      $display("FAIL single_grant: grant=%b adr=%h stb=%b cyc=%b we=%b want 10/40/1/1/0",
               grant, s_adr, s_stb, s_cyc, s_we);
    end
    s_ack = 1; s_dat_i = rd;
    #1;
    n_checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_dat_o !== rd) begin
      n_bad++;
      $display("FAIL single_ack: m1_ack=%b m0_ack=%b dat=%h want 1/0/%h", m1_ack, m0_ack, m1_dat_o, rd);
    end
    step();
    idle_inputs();
    step();
    #1;
    n_checks++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL single_release: grant=%b want 00", grant);
    end
  endtask

  task automatic test_contention();
    logic [1:0] g [16];
    logic [1:0] owners [4];
    logic [1:0] want [4];
    logic a0, a1, prevg;
    int zrun, nown;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 16; i++) begin
      m0_cyc = !a0; m0_stb = !a0; m1_cyc = !a1; m1_stb = !a1; s_ack = 0;
      #1;
      s_ack = s_stb;
      #1;
      g[i] = grant;
      a0 = m0_ack; a1 = m1_ack;
      step();
    end
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    zrun = 0; nown = 0; prevg = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (g[i] == 2'b00) zrun++;
      else begin
        if (nown == 0 || g[i] != owners[(nown - 1) % 4] || zrun != 0) begin
          if (nown < 4) begin
            owners[nown] = g[i];
            if (nown > 0) begin
              n_checks++;
              if (zrun != 1) begin
                n_bad++;
                $display("FAIL contention_gap%0d: idle=%0d want 1", nown, zrun);
              end
            end
          end
          nown++;
        end
        zrun = 0;
      end
    end
    n_checks++;
    if (nown < 4 || owners[0] !== want[0] || owners[1] !== want[1] || owners[2] !== want[2] ||
        owners[3] !== want[3]) begin
      n_bad++;
      $display("FAIL contention_order: grants=%0d seq=%b,%b,%b,%b want 01,10,01,10",
               nown, owners[0], owners[1], owners[2], owners[3]);
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_lock();
    logic [DW-1:0] wd;
    m0_cyc = 1; m0_stb = 1; m0_we = 1;
    step();
    m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 4; i++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      m0_dat = wd; m0_adr = 32'h100 + 32'(i * 16); s_ack = 1;
      #1;
      n_checks++;
      if (grant !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0 || s_we !== 1'b1 || s_dat !== wd ||
          s_adr !== m0_adr) begin
        n_bad++;
        $display("FAIL lock_beat%0d: grant=%b ack=%b%b we=%b dat=%h want 01/m1=0,m0=1/1/%h",
                 i, grant, m1_ack, m0_ack, s_we, s_dat, wd);
      end
      step();
    end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_bad++;
      $display("FAIL lock_drop: grant=%b want 01", grant);
    end
    step();
    n_checks++;
    if (grant !== 2'b00) begin
      n_bad++;
      $display("FAIL lock_idle: grant=%b want 00", grant);
    end
    step();
    n_checks++;
    if (grant !== 2'b10) begin
      n_bad++;
      $display("FAIL lock_handover: grant=%b want 10", grant);
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_abort();
    m0_cyc = 1; m0_stb = 1;
    step();
    m1_cyc = 1; m1_stb = 1; s_ack = 0;
    #1;
    n_checks++;
    if (grant !== 2'b01 || s_stb !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_setup: grant=%b stb=%b want 01/1", grant, s_stb);
    end
    step();
    m0_cyc = 0;
    #1;
    n_checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_bus: s_cyc=%b s_stb=%b want 0/0", s_cyc, s_stb);
    end
    step();
    s_ack = 1;
    #1;
    n_checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || grant !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_late_ack: ack=%b%b grant=%b want 00/00", m1_ack, m0_ack, grant);
    end
    step();
    s_ack = 0;
    #1;
    n_checks++;
    if (grant !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_next: grant=%b want 10", grant);
    end
    idle_inputs();
    m0_stb = 0;
    step();
    step();
  endtask

  task automatic test_timeout();
    m0_cyc = 1; m0_stb = 1; s_ack = 0; s_err = 0;
    step();
    for (int k = 0; k < 10; k++) begin
      #1;
      n_checks++;
`ifdef WB_ARB_TIMEOUT_EN
      if (m0_err !== (k == 8) || s_stb !== (k != 8) || m1_err !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_k%0d: err=%b stb=%b want err=%b stb=%b", k, m0_err, s_stb, k == 8, k != 8);
      end
`else
      if (m0_err !== 1'b0 || grant !== 2'b01 || s_stb !== 1'b1) begin
        n_bad++;
        $display("FAIL hang_k%0d: err=%b grant=%b stb=%b want 0/01/1", k, m0_err, grant, s_stb);
      end
`endif
      step();
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) rst = 0;
      else if ($urandom_range(0, 3) == 0) rst = 1;
      if ($urandom_range(0, 5) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 5) == 0) m1_cyc = ~m1_cyc;
      m0_stb = $urandom_range(0, 3) != 0;
      m1_stb = $urandom_range(0, 3) != 0;
      m0_we  = $urandom_range(0, 1) == 1;
      m1_we  = $urandom_range(0, 1) == 1;
      m0_adr = $urandom; m1_adr = $urandom;
      m0_sel = SW'({$urandom}); m1_sel = SW'({$urandom});
      m0_dat = {$urandom, $urandom, $urandom, $urandom};
      m1_dat = {$urandom, $urandom, $urandom, $urandom};
      s_dat_i = {$urandom, $urandom, $urandom, $urandom};
      s_ack  = $urandom_range(0, 9) < 4;
      s_err  = $urandom_range(0, 15) == 0;
      #1;
      n_checks++;
      if ({grant, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err} !==
          {e_grant, e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1}) begin
        n_bad++;
        $display("FAIL rand_ctrl%0d: grant,cyc,stb,we,ack0,ack1,err0,err1=%b want %b", i,
                 {grant, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err},
                 {e_grant, e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1});
      end
      n_checks++;
      if (s_adr !== e_adr || s_dat !== e_dat || s_sel !== e_sel || m0_dat_o !== s_dat_i ||
          m1_dat_o !== s_dat_i) begin
        n_bad++;
        $display("FAIL rand_data%0d: adr=%h sel=%h dat=%h want adr=%h sel=%h dat=%h", i,
                 s_adr, s_sel, s_dat, e_adr, e_sel, e_dat);
      end
      step();
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    m0_adr = '0; m1_adr = '0; m0_dat = '0; m1_dat = '0; s_dat_i = '0;
    m0_we = 0; m1_we = 0; m0_sel = '1; m1_sel = '1;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_abort();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
